// File: rtl/ram_s2_arbiter_if.sv
// Bus bundle between the two fabric requesters, the s2 arbiter and the RAM s2 port.
interface ram_s2_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic                  m0_req;
  logic                  m0_write;
  logic [ADDR_W-1:0]     m0_addr;
  logic [DATA_W-1:0]     m0_wdata;
  logic [DATA_W/8-1:0]   m0_be;
  logic                  m0_gnt;
  logic                  m0_rvalid;
  logic [DATA_W-1:0]     m0_rdata;

  logic                  m1_req;
  logic                  m1_write;
  logic [ADDR_W-1:0]     m1_addr;
  logic [DATA_W-1:0]     m1_wdata;
  logic [DATA_W/8-1:0]   m1_be;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  logic [DATA_W-1:0]     m1_rdata;

  logic [ADDR_W-1:0]     ram_address;
  logic                  ram_chipselect;
  logic                  ram_clken;
  logic                  ram_write;
  logic [DATA_W-1:0]     ram_writedata;
  logic [DATA_W/8-1:0]   ram_byteenable;
  logic [DATA_W-1:0]     ram_readdata;

  // Arbiter view: serves the requesters, drives the RAM port
  modport slave (
    input  m0_req, m0_write, m0_addr, m0_wdata, m0_be,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_write, m1_addr, m1_wdata, m1_be,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_address, ram_chipselect, ram_clken, ram_write, ram_writedata, ram_byteenable,
    input  ram_readdata
  );

  // Environment view: requesters plus the RAM itself
  modport master (
    output m0_req, m0_write, m0_addr, m0_wdata, m0_be,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_write, m1_addr, m1_wdata, m1_be,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_address, ram_chipselect, ram_clken, ram_write, ram_writedata, ram_byteenable,
    output ram_readdata
  );
endinterface

// File: rtl/ram_s2_arbiter.sv
// Round-robin arbiter/sequencer for the RAM s2 port: mic frame writer (m0) and
// TSE payload reader (m1), one access per cycle, in-order read return.
module ram_s2_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk_clk,
  input  logic          reset_reset,
  input  logic          arb_enable,
  ram_s2_arbiter_if.slave bus,
  output logic [15:0]   gnt_cnt0,
  output logic [15:0]   gnt_cnt1
);
  localparam int BE_W = DATA_W / 8;

  logic              gnt0;
  logic              gnt1;
  logic              any_gnt;
  logic              last_gnt;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic [RD_LATENCY:0] rd_v;
  logic [RD_LATENCY:0] rd_id;

  // Grants are forced low during reset so outputs are at reset values immediately
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (arb_enable && !reset_reset) begin
      if (bus.m0_req && bus.m1_req) begin
        gnt0 = last_gnt;
        gnt1 = !last_gnt;
      end else begin
        gnt0 = bus.m0_req;
        gnt1 = bus.m1_req;
      end
    end
  end

  assign any_gnt    = gnt0 | gnt1;
  assign bus.m0_gnt = gnt0;
  assign bus.m1_gnt = gnt1;

  always_comb begin
    sel_write = bus.m0_write;
    sel_addr  = bus.m0_addr;
    sel_wdata = bus.m0_wdata;
    sel_be    = bus.m0_be;
    if (gnt1) begin
      sel_write = bus.m1_write;
      sel_addr  = bus.m1_addr;
      sel_wdata = bus.m1_wdata;
      sel_be    = bus.m1_be;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      last_gnt           <= 1'b1;
      bus.ram_clken      <= 1'b0;
      bus.ram_chipselect <= 1'b0;
      bus.ram_write      <= 1'b0;
      bus.ram_address    <= '0;
      bus.ram_writedata  <= '0;
      bus.ram_byteenable <= '0;
    end else begin
      bus.ram_clken      <= 1'b1;
      bus.ram_chipselect <= any_gnt;
      bus.ram_write      <= any_gnt & sel_write;
      if (any_gnt) begin
        last_gnt           <= gnt1;
        bus.ram_address    <= sel_addr;
        bus.ram_writedata  <= sel_wdata;
        bus.ram_byteenable <= sel_be;
      end
    end
  end

  // Slot RD_LATENCY lines up with the cycle in which ram_readdata is valid
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rd_v          <= '0;
      rd_id         <= '0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_rdata  <= '0;
    end else begin
      rd_v          <= {rd_v[RD_LATENCY-1:0], any_gnt & !sel_write};
      rd_id         <= {rd_id[RD_LATENCY-1:0], gnt1};
      bus.m0_rvalid <= rd_v[RD_LATENCY] & !rd_id[RD_LATENCY];
      bus.m1_rvalid <= rd_v[RD_LATENCY] & rd_id[RD_LATENCY];
      if (rd_v[RD_LATENCY]) begin
        if (rd_id[RD_LATENCY]) bus.m1_rdata <= bus.ram_readdata;
        else                   bus.m0_rdata <= bus.ram_readdata;
      end
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt0 && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (gnt1 && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + 16'd1;
    end
  end
endmodule
